// File: rtl/two_pointer_partition_array_pkg.sv
// Shared configuration for the partition block: default element width and half-length.
package two_pointer_partition_array_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_NUM_DATA   = 8;

endpackage

// File: rtl/two_pointer_partition_array.sv
// Stable two-pointer partition: loads 2*NUM_DATA words, splits them around a pivot into
// order-preserving lo (< pivot) and hi (>= pivot) arrays, then streams both out pairwise.
module two_pointer_partition_array
  import two_pointer_partition_array_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_DATA   = DEF_NUM_DATA,
  localparam int unsigned CW        = $clog2(2 * NUM_DATA) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic                  compute_start,
  input  logic [DATA_WIDTH-1:0] pivot,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dataout_lo,
  output logic [DATA_WIDTH-1:0] dataout_hi,
  output logic                  valid_lo,
  output logic                  valid_hi,
  output logic [CW-1:0]         count_lo,
  output logic [CW-1:0]         count_hi,
  output logic                  done
);

  localparam int unsigned DEPTH = 2 * NUM_DATA;
  localparam int unsigned IW    = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] buff_in [DEPTH];
  logic [DATA_WIDTH-1:0] buff_lo [DEPTH];
  logic [DATA_WIDTH-1:0] buff_hi [DEPTH];

  logic [CW-1:0]         wr_count;
  logic [CW-1:0]         k;
  logic [CW-1:0]         i;
  logic [CW-1:0]         j;
  logic [CW-1:0]         rd_count;
  logic [DATA_WIDTH-1:0] pivot_q;

  logic                  wr_accept;
  logic                  start_accept;
  logic [DATA_WIDTH-1:0] cur;
  logic                  cur_is_lo;
  logic                  rd_lo_hit;
  logic                  rd_hi_hit;
  logic [IW-1:0]         rd_idx;

  // Handshake qualifiers and the element currently being classified.
  always_comb begin
    wr_accept    = (state_q == ST_IDLE) && wr_en && (wr_count != FULL);
    start_accept = (state_q == ST_IDLE) && compute_start && (wr_count == FULL);
    cur          = buff_in[k[IW-1:0]];
    cur_is_lo    = (cur < pivot_q);
    rd_idx       = rd_count[IW-1:0];
    rd_lo_hit    = (rd_count < i);
    rd_hi_hit    = (rd_count < j);
  end

  // Next-state logic; DONE is left only through rst.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start_accept) state_d = ST_COMPUTE;
      ST_COMPUTE: if (k == LAST) state_d = ST_DONE;
      ST_DONE:    state_d = ST_DONE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Storage arrays carry no reset; their contents are don't-care until rewritten.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr_accept) buff_in[wr_count[IW-1:0]] <= datain;
      if (state_q == ST_COMPUTE) begin
        if (cur_is_lo) buff_lo[i[IW-1:0]] <= cur;
        else           buff_hi[j[IW-1:0]] <= cur;
      end
    end
  end

  // Control, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_count   <= '0;
      k          <= '0;
      i          <= '0;
      j          <= '0;
      rd_count   <= '0;
      pivot_q    <= '0;
      dataout_lo <= '0;
      dataout_hi <= '0;
      valid_lo   <= 1'b0;
      valid_hi   <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_IDLE: begin
          if (wr_accept) wr_count <= wr_count + CW'(1);
          if (start_accept) begin
            pivot_q <= pivot;
            k       <= '0;
            i       <= '0;
            j       <= '0;
          end
        end
        ST_COMPUTE: begin
          k <= k + CW'(1);
          if (cur_is_lo) i <= i + CW'(1);
          else           j <= j + CW'(1);
          if (k == LAST) done <= 1'b1;
        end
        ST_DONE: begin
          if (rd_en) begin
            dataout_lo <= rd_lo_hit ? buff_lo[rd_idx] : '0;
            valid_lo   <= rd_lo_hit;
            dataout_hi <= rd_hi_hit ? buff_hi[rd_idx] : '0;
            valid_hi   <= rd_hi_hit;
            if (rd_count != FULL) rd_count <= rd_count + CW'(1);
          end else begin
            valid_lo <= 1'b0;
            valid_hi <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign count_lo = i;
  assign count_hi = j;

endmodule

// File: tb/tb_two_pointer_partition_array.sv
// Self-checking bench: directed and randomized loads compared against a queue-based partition model.
module tb_two_pointer_partition_array;

  localparam int unsigned DW = 8;
  localparam int unsigned ND = 8;
  localparam int unsigned N2 = 2 * ND;
  localparam int unsigned CW = $clog2(N2) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] datain;
  logic          compute_start;
  logic [DW-1:0] pivot;
  logic          rd_en;
  logic [DW-1:0] dataout_lo;
  logic [DW-1:0] dataout_hi;
  logic          valid_lo;
  logic          valid_hi;
  logic [CW-1:0] count_lo;
  logic [CW-1:0] count_hi;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] vec [N2];
  logic [DW-1:0] lo_q [$];
  logic [DW-1:0] hi_q [$];

  two_pointer_partition_array #(.DATA_WIDTH(DW), .NUM_DATA(ND)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .datain(datain),
    .compute_start(compute_start), .pivot(pivot), .rd_en(rd_en),
    .dataout_lo(dataout_lo), .dataout_hi(dataout_hi),
    .valid_lo(valid_lo), .valid_hi(valid_hi),
    .count_lo(count_lo), .count_hi(count_hi), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; datain = '0; compute_start = 1'b0; pivot = '0; rd_en = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_cnt_lo"}, 32'(count_lo), 32'd0);
    chk({tag, "_cnt_hi"}, 32'(count_hi), 32'd0);
    chk({tag, "_vld"}, {30'd0, valid_lo, valid_hi}, 32'd0);
    chk({tag, "_data"}, {16'd0, dataout_lo, dataout_hi}, 32'd0);
  endtask

  task automatic load(input int first, input int n);
    for (int e = first; e < first + n; e++) begin
      wr_en = 1'b1; datain = vec[e];
      step();
    end
    wr_en = 1'b0;
  endtask

  // Reference partition: stable filter of the loaded array by the pivot.
  task automatic model(input logic [DW-1:0] pv);
    lo_q.delete();
    hi_q.delete();
    for (int e = 0; e < int'(N2); e++) begin
      if (vec[e] < pv) lo_q.push_back(vec[e]);
      else             hi_q.push_back(vec[e]);
    end
  endtask

  // Pulse start, then count edges until done; expect exactly N2 edges.
  task automatic start_and_wait(input string tag, input logic [DW-1:0] pv);
    int lat;
    compute_start = 1'b1; pivot = pv;
    step();
    compute_start = 1'b0; pivot = ~pv;
    lat = 0;
    while (done !== 1'b1 && lat < 4 * int'(N2)) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(N2));
    model(pv);
    chk({tag, "_cnt_lo"}, 32'(count_lo), 32'(lo_q.size()));
    chk({tag, "_cnt_hi"}, 32'(count_hi), 32'(hi_q.size()));
  endtask

  task automatic read_and_check(input string tag, input int nreads);
    logic [DW-1:0] last_lo, last_hi;
    last_lo = '0; last_hi = '0;
    for (int r = 0; r < nreads; r++) begin
      rd_en = 1'b1;
      step();
      if (r < lo_q.size()) begin
        chk({tag, "_lo"}, {23'd0, valid_lo, dataout_lo}, {23'd0, 1'b1, lo_q[r]});
        last_lo = lo_q[r];
      end else begin
        chk({tag, "_lo_empty"}, {23'd0, valid_lo, dataout_lo}, 32'd0);
        last_lo = '0;
      end
      if (r < hi_q.size()) begin
        chk({tag, "_hi"}, {23'd0, valid_hi, dataout_hi}, {23'd0, 1'b1, hi_q[r]});
        last_hi = hi_q[r];
      end else begin
        chk({tag, "_hi_empty"}, {23'd0, valid_hi, dataout_hi}, 32'd0);
        last_hi = '0;
      end
    end
    rd_en = 1'b0;
    step();
    chk({tag, "_hold"}, {14'd0, valid_lo, valid_hi, dataout_lo, dataout_hi},
        {14'd0, 2'b00, last_lo, last_hi});
  endtask

  initial begin
    // Reset state
    do_reset();
    chk_idle_outputs("reset");

    // Ascending data, pivot 8; extra reads past the end exercise saturation
    for (int e = 0; e < int'(N2); e++) vec[e] = DW'(e);
    load(0, N2);
    start_and_wait("asc", 8'd8);
    read_and_check("asc", 20);

    // Interleaved data; order must be preserved; writes in DONE are ignored
    do_reset();
    vec = '{8'd9, 8'd3, 8'd12, 8'd1, 8'd15, 8'd7, 8'd0, 8'd8,
            8'd200, 8'd6, 8'd8, 8'd2, 8'd100, 8'd5, 8'd10, 8'd4};
    load(0, N2);
    start_and_wait("mix", 8'd8);
    wr_en = 1'b1; datain = 8'hEE;
    step(); step();
    wr_en = 1'b0;
    read_and_check("mix", N2);

    // All equal to pivot -> everything in hi
    do_reset();
    for (int e = 0; e < int'(N2); e++) vec[e] = 8'd5;
    load(0, N2);
    start_and_wait("eq", 8'd5);
    read_and_check("eq", N2);

    // Pivot 0 on random data -> everything in hi
    do_reset();
    for (int e = 0; e < int'(N2); e++) vec[e] = DW'($urandom);
    load(0, N2);
    start_and_wait("piv0", 8'd0);
    read_and_check("piv0", 4);

    // Early start and early rd_en ignored; 17th write dropped
    do_reset();
    for (int e = 0; e < int'(N2); e++) vec[e] = DW'($urandom_range(0, 63));
    load(0, 10);
    compute_start = 1'b1; pivot = 8'd32; rd_en = 1'b1;
    step();
    compute_start = 1'b0; rd_en = 1'b0;
    for (int c = 0; c < 20; c++) step();
    chk_idle_outputs("early");
    load(10, 5);
    wr_en = 1'b1; datain = vec[15]; compute_start = 1'b1; pivot = 8'd32;
    step();
    wr_en = 1'b0; compute_start = 1'b0;
    for (int c = 0; c < 20; c++) step();
    chk("same_edge_done", 32'(done), 32'd0);
    wr_en = 1'b1; datain = 8'hFF;
    step();
    wr_en = 1'b0;
    start_and_wait("late", 8'd32);
    read_and_check("late", N2);

    // Reset mid-compute, then reload and rerun
    do_reset();
    for (int e = 0; e < int'(N2); e++) vec[e] = DW'($urandom);
    load(0, N2);
    compute_start = 1'b1; pivot = 8'd128;
    step();
    compute_start = 1'b0;
    for (int c = 0; c < 5; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle_outputs("midrst");
    for (int e = 0; e < int'(N2); e++) vec[e] = DW'($urandom);
    load(0, N2);
    start_and_wait("rerun", 8'd128);
    read_and_check("rerun", N2);

    // Exactly three lo elements, ten reads
    do_reset();
    for (int e = 0; e < int'(N2); e++) vec[e] = DW'($urandom_range(50, 255));
    vec[2] = 8'd7; vec[9] = 8'd1; vec[14] = 8'd30;
    load(0, N2);
    start_and_wait("three", 8'd50);
    read_and_check("three", 10);

    // Randomized rounds with a narrow value range to hit pivot ties
    for (int t = 0; t < 6; t++) begin
      logic [DW-1:0] pv;
      do_reset();
      for (int e = 0; e < int'(N2); e++) vec[e] = DW'($urandom_range(0, 20));
      pv = DW'($urandom_range(0, 21));
      load(0, N2);
      start_and_wait("rand", pv);
      read_and_check("rand", N2 + 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
